// File: rtl/CPU_Definitions.sv
// Shared types for the front-panel console controller: machine word, console
// sequencer states and display-select codes.
package CPU_Definitions;

  typedef logic [11:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    DEP_REQ,
    DEP_INC,
    STEP_WAIT,
    RUN
  } fp_state_t;

  typedef enum logic [1:0] {
    SEL_PC = 2'b00,
    SEL_AC = 2'b01,
    SEL_MA = 2'b10,
    SEL_MB = 2'b11
  } disp_sel_t;

endpackage

// File: rtl/fp_disp_mux.sv
// Registered 4:1 front-panel display select plus the registered link lamp.
module fp_disp_mux
  import CPU_Definitions::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  dispsel,
  input  logic [11:0] pc,
  input  logic [11:0] ac,
  input  logic [11:0] ma,
  input  logic [11:0] mb,
  input  logic        link,
  output logic [11:0] dispout,
  output logic        linkout
);

  word_t disp_nxt;
  word_t disp_p1;
  logic  link_p1;

  always_comb begin
    disp_nxt = pc;
    case (disp_sel_t'(dispsel))
      SEL_PC: disp_nxt = pc;
      SEL_AC: disp_nxt = ac;
      SEL_MA: disp_nxt = ma;
      SEL_MB: disp_nxt = mb;
    endcase
  end

  // stage p1: lamp registers
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_p1 <= '0;
      link_p1 <= 1'b0;
    end else begin
      disp_p1 <= disp_nxt;
      link_p1 <= link;
    end
  end

  assign dispout = disp_p1;
  assign linkout = link_p1;

endmodule

// File: rtl/fp_console_ctrl.sv
// Front-panel console sequencer: register loads, memory deposit with ack
// timeout, single step and run/halt control. All strobes are registered.
module fp_console_ctrl
  import CPU_Definitions::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadpc,
  input  logic        loadac,
  input  logic        deposit,
  input  logic        step,
  input  logic        run,
  input  logic [11:0] swreg,
  input  logic [1:0]  dispsel,
  input  logic [11:0] cpu_pc,
  input  logic [11:0] cpu_ac,
  input  logic [11:0] cpu_mb,
  input  logic        cpu_link,
  input  logic        cpu_done,
  input  logic        cpu_hlt,
  output logic        cpu_go,
  output logic        cpu_pc_ld,
  output logic        cpu_ac_ld,
  output logic        cpu_pc_inc,
  output logic [11:0] ld_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic        mem_ack,
  output logic [11:0] dispout,
  output logic        linkout,
  output logic        halt,
  output logic        err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  fp_state_t        state, state_nxt;
  word_t            ma, ma_nxt;
  word_t            mbw, mbw_nxt;
  word_t            ld_nxt;
  logic [CNT_W-1:0] ack_cnt, ack_cnt_nxt;
  logic             halt_lat, halt_lat_nxt;
  logic             run_q, run_rise, halt_eff;
  logic             err_nxt, go_pulse, pc_ld_nxt, ac_ld_nxt;

  // A fresh run edge clears the halt latch in time to enter RUN on that edge.
  assign run_rise = run & ~run_q;
  assign halt_eff = halt_lat & ~run_rise;

  always_comb begin
    state_nxt    = state;
    ma_nxt       = ma;
    mbw_nxt      = mbw;
    ack_cnt_nxt  = ack_cnt;
    halt_lat_nxt = halt_eff;
    err_nxt      = err;
    ld_nxt       = '0;
    pc_ld_nxt    = 1'b0;
    ac_ld_nxt    = 1'b0;
    go_pulse     = 1'b0;
    case (state)
      IDLE: begin
        if (loadpc) begin
          pc_ld_nxt = 1'b1;
          ld_nxt    = swreg;
          err_nxt   = 1'b0;
        end else if (loadac) begin
          ac_ld_nxt = 1'b1;
          ld_nxt    = swreg;
        end else if (deposit) begin
          ma_nxt      = cpu_pc;
          mbw_nxt     = swreg;
          ack_cnt_nxt = '0;
          state_nxt   = DEP_REQ;
        end else if (run && !halt_eff) begin
          state_nxt = RUN;
        end else if (step && !run) begin
          go_pulse  = 1'b1;
          state_nxt = STEP_WAIT;
        end
      end
      DEP_REQ: begin
        if (mem_ack) begin
          state_nxt = DEP_INC;
        end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      DEP_INC:   state_nxt = IDLE;
      STEP_WAIT: if (cpu_done) state_nxt = IDLE;
      RUN: begin
        if (cpu_done && (cpu_hlt || !run)) begin
          state_nxt = IDLE;
          if (cpu_hlt) halt_lat_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ma         <= '0;
      mbw        <= '0;
      ack_cnt    <= '0;
      halt_lat   <= 1'b0;
      run_q      <= 1'b0;
      err        <= 1'b0;
      cpu_go     <= 1'b0;
      cpu_pc_ld  <= 1'b0;
      cpu_ac_ld  <= 1'b0;
      cpu_pc_inc <= 1'b0;
      ld_data    <= '0;
      mem_req    <= 1'b0;
      halt       <= 1'b1;
    end else begin
      state      <= state_nxt;
      ma         <= ma_nxt;
      mbw        <= mbw_nxt;
      ack_cnt    <= ack_cnt_nxt;
      halt_lat   <= halt_lat_nxt;
      run_q      <= run;
      err        <= err_nxt;
      cpu_go     <= go_pulse | (state_nxt == RUN);
      cpu_pc_ld  <= pc_ld_nxt;
      cpu_ac_ld  <= ac_ld_nxt;
      cpu_pc_inc <= (state_nxt == DEP_INC);
      ld_data    <= ld_nxt;
      mem_req    <= (state_nxt == DEP_REQ);
      halt       <= !((state_nxt == RUN) || (state_nxt == STEP_WAIT));
    end
  end

  assign mem_we    = mem_req;
  assign mem_addr  = ma;
  assign mem_wdata = mbw;

  fp_disp_mux u_disp (
    .clock   (clock),
    .reset   (reset),
    .dispsel (dispsel),
    .pc      (cpu_pc),
    .ac      (cpu_ac),
    .ma      (ma),
    .mb      (cpu_mb),
    .link    (cpu_link),
    .dispout (dispout),
    .linkout (linkout)
  );

endmodule

// File: tb/tb_fp_console_ctrl.sv
// Scoreboard bench for fp_console_ctrl: a console behaviour model predicts every
// output after each clock edge; a monitor pops and compares the predictions.
module tb_fp_console_ctrl;

  localparam int ACK_TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset, loadpc, loadac, deposit, step, run;
  logic [11:0] swreg, cpu_pc, cpu_ac, cpu_mb;
  logic [1:0]  dispsel;
  logic        cpu_link, cpu_done, cpu_hlt, mem_ack;
  logic        cpu_go, cpu_pc_ld, cpu_ac_ld, cpu_pc_inc, mem_req, mem_we;
  logic        linkout, halt, err;
  logic [11:0] ld_data, mem_addr, mem_wdata, dispout;

  fp_console_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .loadpc     (loadpc),
    .loadac     (loadac),
    .deposit    (deposit),
    .step       (step),
    .run        (run),
    .swreg      (swreg),
    .dispsel    (dispsel),
    .cpu_pc     (cpu_pc),
    .cpu_ac     (cpu_ac),
    .cpu_mb     (cpu_mb),
    .cpu_link   (cpu_link),
    .cpu_done   (cpu_done),
    .cpu_hlt    (cpu_hlt),
    .cpu_go     (cpu_go),
    .cpu_pc_ld  (cpu_pc_ld),
    .cpu_ac_ld  (cpu_ac_ld),
    .cpu_pc_inc (cpu_pc_inc),
    .ld_data    (ld_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .dispout    (dispout),
    .linkout    (linkout),
    .halt       (halt),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        go, pc_ld, ac_ld, inc, mreq, mwe, link, halt, err;
    logic [11:0] ld, maddr, mwdata, disp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Console model: what the panel is busy with, not how the RTL encodes it.
  typedef enum int {M_IDLE, M_DEPOSIT, M_INCREMENT, M_STEPPING, M_RUNNING} mode_t;
  mode_t       m_mode;
  logic [11:0] m_ma, m_mbw;
  logic        m_halted, m_err, m_run_prev;
  int          m_budget;
  int          wait_n, ack_plan, ack_plan_next;

  function automatic void model_step();
    exp_t e;
    logic rise;
    e = '0;
    if (reset) begin
      m_mode     = M_IDLE;
      m_ma       = '0;
      m_mbw      = '0;
      m_halted   = 1'b0;
      m_err      = 1'b0;
      m_run_prev = 1'b0;
      e.halt     = 1'b1;
    end else begin
      e.disp = (dispsel == 2'd0) ? cpu_pc :
               (dispsel == 2'd1) ? cpu_ac :
               (dispsel == 2'd2) ? m_ma : cpu_mb;
      e.link = cpu_link;
      rise = run && !m_run_prev;
      m_run_prev = run;
      if (rise) m_halted = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (loadpc) begin
            e.pc_ld = 1'b1; e.ld = swreg; m_err = 1'b0;
          end else if (loadac) begin
            e.ac_ld = 1'b1; e.ld = swreg;
          end else if (deposit) begin
            m_ma = cpu_pc; m_mbw = swreg; m_mode = M_DEPOSIT;
            m_budget = ACK_TIMEOUT; ack_plan = ack_plan_next; wait_n = 0;
          end else if (run && !m_halted) begin
            m_mode = M_RUNNING;
          end else if (step && !run) begin
            e.go = 1'b1; m_mode = M_STEPPING;
          end
        end
        M_DEPOSIT: begin
          m_budget--;
          if (mem_ack) m_mode = M_INCREMENT;
          else if (m_budget == 0) begin m_mode = M_IDLE; m_err = 1'b1; end
        end
        M_INCREMENT: m_mode = M_IDLE;
        M_STEPPING:  if (cpu_done) m_mode = M_IDLE;
        M_RUNNING: begin
          if (cpu_done && cpu_hlt) begin m_mode = M_IDLE; m_halted = 1'b1; end
          else if (cpu_done && !run) m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
      e.go   = e.go | (m_mode == M_RUNNING);
      e.mreq = (m_mode == M_DEPOSIT);
      e.mwe  = e.mreq;
      e.inc  = (m_mode == M_INCREMENT);
      e.halt = !((m_mode == M_RUNNING) || (m_mode == M_STEPPING));
    end
    e.err    = m_err;
    e.maddr  = m_ma;
    e.mwdata = m_mbw;
    exp_q.push_back(e);
  endfunction

  // The memory answers a deposit on the cycle chosen by ack_plan.
  task automatic tick();
    if (m_mode == M_DEPOSIT) begin
      wait_n++;
      mem_ack = (wait_n == ack_plan);
    end else begin
      mem_ack = 1'b0;
    end
    model_step();
    @(negedge clock);
    loadpc = 1'b0; loadac = 1'b0; deposit = 1'b0; step = 1'b0;
    cpu_done = 1'b0; cpu_hlt = 1'b0;
  endtask

  function automatic void chk1(input string nm, input logic a, input logic x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, x, $time);
    end
  endfunction

  function automatic void chk12(input string nm, input logic [11:0] a, input logic [11:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %04o expected %04o at %0t", nm, a, x, $time);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk1 ("cpu_go",     cpu_go,     e.go);
        chk1 ("cpu_pc_ld",  cpu_pc_ld,  e.pc_ld);
        chk1 ("cpu_ac_ld",  cpu_ac_ld,  e.ac_ld);
        chk1 ("cpu_pc_inc", cpu_pc_inc, e.inc);
        chk1 ("mem_req",    mem_req,    e.mreq);
        chk1 ("mem_we",     mem_we,     e.mwe);
        chk1 ("linkout",    linkout,    e.link);
        chk1 ("halt",       halt,       e.halt);
        chk1 ("err",        err,        e.err);
        chk12("ld_data",    ld_data,    e.ld);
        chk12("mem_addr",   mem_addr,   e.maddr);
        chk12("mem_wdata",  mem_wdata,  e.mwdata);
        chk12("dispout",    dispout,    e.disp);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1; loadpc = 1'b0; loadac = 1'b0; deposit = 1'b0; step = 1'b0;
    run = 1'b0; swreg = '0; dispsel = '0; cpu_pc = '0; cpu_ac = '0; cpu_mb = '0;
    cpu_link = 1'b0; cpu_done = 1'b0; cpu_hlt = 1'b0; mem_ack = 1'b0;
    m_mode = M_IDLE; wait_n = 0; ack_plan = 0; ack_plan_next = 3;
    tick(); tick();
    reset = 1'b0;

    swreg = 12'o0200; loadpc = 1'b1; tick(); tick();

    cpu_pc = 12'o0200; swreg = 12'o7402; ack_plan_next = 3; deposit = 1'b1; tick();
    repeat (5) tick();

    ack_plan_next = 1000; deposit = 1'b1; tick();
    repeat (ACK_TIMEOUT + 2) tick();
    loadpc = 1'b1; tick(); tick();

    // ack on the last allowed cycle, then one cycle too late
    ack_plan_next = ACK_TIMEOUT; deposit = 1'b1; tick();
    repeat (ACK_TIMEOUT + 2) tick();
    ack_plan_next = ACK_TIMEOUT + 1; deposit = 1'b1; tick();
    repeat (ACK_TIMEOUT + 2) tick();
    loadpc = 1'b1; tick();

    run = 1'b1; repeat (3) tick();
    cpu_done = 1'b1; cpu_hlt = 1'b1; tick();
    repeat (3) tick();
    run = 1'b0; tick();
    run = 1'b1; repeat (3) tick();
    run = 1'b0; tick(); tick();
    cpu_done = 1'b1; tick(); tick();

    swreg = 12'o1357; loadac = 1'b1; step = 1'b1; tick();
    step = 1'b1; tick();
    step = 1'b1; tick();
    repeat (2) tick();
    cpu_done = 1'b1; tick(); tick();

    cpu_pc = 12'o1234; cpu_ac = 12'o5670; cpu_mb = 12'o7777; cpu_link = 1'b1;
    for (int s = 0; s < 4; s++) begin
      dispsel = 2'(s);
      tick();
    end
    tick();

    ack_plan_next = 1000; deposit = 1'b1; tick(); tick();
    reset = 1'b1; tick();
    reset = 1'b0; tick();

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      loadpc   = ($urandom_range(0, 11) == 0);
      loadac   = ($urandom_range(0, 11) == 0);
      deposit  = ($urandom_range(0, 5) == 0);
      step     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      swreg    = 12'($urandom);
      dispsel  = 2'($urandom);
      cpu_pc   = 12'($urandom);
      cpu_ac   = 12'($urandom);
      cpu_mb   = 12'($urandom);
      cpu_link = 1'($urandom);
      cpu_done = ($urandom_range(0, 3) == 0);
      cpu_hlt  = cpu_done && ($urandom_range(0, 2) == 0);
      ack_plan_next = int'($urandom_range(1, ACK_TIMEOUT + 3));
      tick();
    end

    @(posedge clock);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_console_ctrl.md
FP_CONSOLE_CTRL -- requirements
Module: fp_console_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles waited for mem_ack before a deposit is abandoned.
REQ-002 clock  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 loadpc, loadac, deposit, step  in  1 each  one-cycle command pulses from front panel.
REQ-005 run  in  1  level; power/run switch state from front panel.
REQ-006 swreg  in  12  switch register value.
REQ-007 dispsel  in  2  display select: 00 PC, 01 AC, 10 MA, 11 MB.
REQ-008 cpu_pc, cpu_ac, cpu_mb  in  12 each; cpu_link  in  1  live CPU register values.
REQ-009 cpu_done  in  1  one-cycle pulse, CPU finished current instruction.
REQ-010 cpu_hlt  in  1  one-cycle pulse with cpu_done when HLT executed.
REQ-011 cpu_go  out  1  CPU may fetch/execute; cpu_pc_ld, cpu_ac_ld, cpu_pc_inc  out  1  one-cycle load/increment strobes; ld_data  out  12  load value.
REQ-012 mem_req, mem_we  out  1; mem_addr, mem_wdata  out  12; mem_ack  in  1  memory write handshake.
REQ-013 dispout  out  12; linkout  out  1; halt  out  1  to front panel.
REQ-014 err  out  1  sticky deposit-timeout flag.

Function
REQ-015 States: IDLE, DEP_REQ, DEP_INC, STEP_WAIT, RUN; reset enters IDLE.
REQ-016 Commands accepted only in IDLE; pulses arriving in any other state are dropped, not queued.
REQ-017 Simultaneous pulses: priority loadpc > loadac > deposit > step; lower-priority pulses dropped.
REQ-018 loadpc in IDLE: cpu_pc_ld=1 and ld_data=swreg for exactly one cycle; stay IDLE.
REQ-019 loadac in IDLE: cpu_ac_ld=1 and ld_data=swreg for exactly one cycle; stay IDLE.
REQ-020 deposit in IDLE: capture MA<=cpu_pc, MBW<=swreg, go DEP_REQ.
REQ-021 DEP_REQ: mem_req=mem_we=1, mem_addr=MA, mem_wdata=MBW held stable until mem_ack; ack -> DEP_INC.
REQ-022 DEP_REQ timeout: after ACK_TIMEOUT cycles without ack, drop mem_req, set err, go IDLE, no increment.
REQ-023 DEP_INC: cpu_pc_inc=1 for one cycle (PC wraps 7777->0000 in CPU), go IDLE.
REQ-024 step in IDLE (run=0): cpu_go=1 for one cycle, go STEP_WAIT; cpu_go=0 while waiting; cpu_done -> IDLE.
REQ-025 IDLE with run=1 and halt latch clear -> RUN; cpu_go=1 continuously in RUN.
REQ-026 RUN exit on cpu_done with cpu_hlt=1 (set halt latch) or with run=0; never mid-instruction.
REQ-027 Halt latch cleared only by rising edge of run (registered run compare) or reset.
REQ-028 halt=1 in every state except RUN and STEP_WAIT.
REQ-029 dispout registered, 1-cycle latency: sel 00 cpu_pc, 01 cpu_ac, 10 MA, 11 cpu_mb.
REQ-030 linkout registered copy of cpu_link, 1-cycle latency.
REQ-031 err cleared only by reset or an accepted loadpc.

Reset
REQ-032 reset has priority over all inputs; state IDLE, MA=MBW=0, halt latch=0, err=0.
REQ-033 Outputs after reset: cpu_go, cpu_pc_ld, cpu_ac_ld, cpu_pc_inc, mem_req, mem_we=0; ld_data, mem_addr, mem_wdata, dispout=0; linkout=0; halt=1.
REQ-034 reset mid-deposit deasserts mem_req in the same edge; no increment issued.

Structure
REQ-035 State enum, dispsel encodings and 12-bit word typedef live in shared package CPU_Definitions.
REQ-036 One sub-module fp_disp_mux (registered 4:1 display select plus link register); rest in one FSM.

Verification
REQ-037 swreg=0200, loadpc -> cpu_pc_ld=1, ld_data=0200 one cycle; halt stays 1.
REQ-038 cpu_pc=0200, swreg=7402, deposit, mem_ack 3 cycles later -> mem_addr=0200, wdata=7402 held 3 cycles, then one cpu_pc_inc.
REQ-039 deposit with no mem_ack -> mem_req drops after 15 cycles, err=1, no cpu_pc_inc; loadpc clears err.
REQ-040 run=1 -> cpu_go=1, halt=0; cpu_done+cpu_hlt -> IDLE, halt=1; run held 1 stays IDLE; run 0->1 resumes RUN.
REQ-041 loadac and step same cycle -> only cpu_ac_ld; step pulse during STEP_WAIT ignored; cpu_done returns IDLE.
REQ-042 dispsel 00..11 with pc=1234, ac=5670, MA=0200, mb=7777 -> dispout follows one cycle later.
